mem_line_responder: RTL and testbench

- External-memory endpoint that sits on the far side of the memory controller's mem_* interface and answers its cache-line read and write requests.
- Provides line-granular backing storage with a configurable fixed response latency.
- Holds up to QUEUE_DEPTH outstanding requests and returns responses strictly in acceptance order.
- Used as the memory model in NoC system simulation and as the front-end of an on-chip SRAM memory target.

---
 rtl/mem_line_responder_pkg.sv | 19 +
 rtl/mem_line_responder_if.sv | 27 ++
 rtl/mem_line_responder_fifo.sv | 59 +++++
 rtl/mem_line_responder.sv | 111 +++++++++++
 tb/tb_mem_line_responder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_line_responder_pkg.sv
// Shared types for the memory line responder: line geometry, the queue
// entry layout and the countdown width used for response latency.
package mem_pkg;

    localparam int DATA_WIDTH  = 64;
    localparam int LINE_WORDS  = 8;
    localparam int OFFSET_BITS = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int CNT_WIDTH   = 8;

    typedef logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_t;

    typedef struct packed {
        logic                 is_write;
        logic                 oob;
        line_t                data;
        logic [CNT_WIDTH-1:0] countdown;
    } entry_t;

endpackage

// File: rtl/mem_line_responder_if.sv
// Request/response bus between the memory controller (master) and the
// line responder (slave).
interface mem_line_responder_if #(
    parameter int ADDR_WIDTH = 48
);
    import mem_pkg::*;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_write;
    line_t                 mem_wdata;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    line_t                 mem_rdata;
    logic                  mem_resp_valid;
    logic                  mem_resp_ready;

    modport master (
        output mem_addr, mem_write, mem_wdata, mem_req_valid, mem_resp_ready,
        input  mem_req_ready, mem_rdata, mem_resp_valid
    );

    modport slave (
        input  mem_addr, mem_write, mem_wdata, mem_req_valid, mem_resp_ready,
        output mem_req_ready, mem_rdata, mem_resp_valid
    );

endinterface

// File: rtl/mem_line_responder_fifo.sv
// Circular queue of outstanding requests. Every slot counts its own latency
// down independently of its position, but only the head may be presented.
module mem_line_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output logic   head_ready,
    output entry_t head_entry
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t             entries [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Slot storage: load on push, otherwise tick each nonzero countdown.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr == PTR_W'(i))) begin
                entries[i] <= push_entry;
            end else if (entries[i].countdown != '0) begin
                entries[i].countdown <= entries[i].countdown - 1'b1;
            end
        end
    end

    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign empty      = (count == '0);
    assign head_entry = entries[rd_ptr];
    assign head_ready = !empty && (head_entry.countdown == '0);

endmodule

// File: rtl/mem_line_responder.sv
// Line-granular memory endpoint answering read/write requests in order with
// a fixed response latency. Optional feature macro: MEM_RESP_JITTER_EN adds
// 0..3 cycles of LFSR-driven latency jitter per request.
module mem_line_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 48,
    parameter int MEM_LINES   = 1024,
    parameter int LATENCY     = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_line_responder_if.slave  mem,
    output logic [31:0]          req_count,
    output logic [31:0]          oob_count
);

    localparam int IDX_BITS = $clog2(MEM_LINES);
    localparam int TAG_LSB  = OFFSET_BITS + IDX_BITS;
    localparam logic [CNT_WIDTH-1:0] LOAD_BASE = CNT_WIDTH'(LATENCY - 1);

    line_t                storage [MEM_LINES];
    logic [IDX_BITS-1:0]  idx;
    logic                 oob;
    logic                 accept;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 head_ready;
    entry_t               new_entry;
    entry_t               head_entry;
    logic [CNT_WIDTH-1:0] jitter;
    logic                 addr_unused;
    logic                 cnt_unused;
    logic                 empty_unused;

    assign idx          = mem.mem_addr[OFFSET_BITS +: IDX_BITS];
    assign oob          = |mem.mem_addr[ADDR_WIDTH-1:TAG_LSB];
    assign addr_unused  = ^mem.mem_addr[OFFSET_BITS-1:0];
    assign cnt_unused   = |head_entry.countdown;
    assign empty_unused = empty;

    assign mem.mem_req_ready  = !full && reset_n;
    assign accept             = mem.mem_req_valid && mem.mem_req_ready;
    assign mem.mem_resp_valid = head_ready;
    assign pop                = head_ready && mem.mem_resp_ready;
    assign mem.mem_rdata      = (head_ready && !head_entry.is_write && !head_entry.oob)
                                ? head_entry.data : '0;

`ifdef MEM_RESP_JITTER_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR (taps 16,14,13,11) stepped once per accepted request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr <= 16'hACE1;
        end else if (accept) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign jitter = CNT_WIDTH'(lfsr[1:0]);
`else
    assign jitter = '0;
`endif

    // Build the queue entry; reads sample storage now so earlier writes are seen.
    always_comb begin
        new_entry           = '0;
        new_entry.is_write  = mem.mem_write;
        new_entry.oob       = oob;
        new_entry.countdown = LOAD_BASE + jitter;
        if (!mem.mem_write && !oob) begin
            new_entry.data = storage[idx];
        end
    end

    // Backing store update at the accept edge; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (accept && mem.mem_write && !oob) begin
            storage[idx] <= mem.mem_wdata;
        end
    end

    // Request statistics, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_count <= '0;
            oob_count <= '0;
        end else if (accept) begin
            req_count <= req_count + 32'd1;
            if (oob) oob_count <= oob_count + 32'd1;
        end
    end

    mem_line_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (accept),
        .push_entry (new_entry),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .head_ready (head_ready),
        .head_entry (head_entry)
    );

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed and random checks of mem_line_responder with an in-order
// scoreboard. Define MEM_RESP_JITTER_EN to relax latency to a range.
module tb_mem_line_responder;
    import mem_pkg::*;

    localparam int LAT       = 4;
    localparam int DEPTH     = 4;
    localparam int MEM_LINES = 1024;

    typedef struct {
        line_t data;
        int    acc;
        int    mode;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] req_count;
    logic [31:0] oob_count;

    mem_line_responder_if #(.ADDR_WIDTH(48)) mem ();

    mem_line_responder #(
        .ADDR_WIDTH  (48),
        .MEM_LINES   (MEM_LINES),
        .LATENCY     (LAT),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem       (mem.slave),
        .req_count (req_count),
        .oob_count (oob_count)
    );

    always #5 clk = ~clk;

    exp_t  sb[$];
    int    pops[$];
    line_t model [MEM_LINES];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    nreq = 0;
    int    noob = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard, checks data, latency and stall hold
    exp_t  mon_e;
    int    mon_lat;
    logic  stall_prev = 1'b0;
    line_t stall_data;

    always @(negedge clk) begin
        if (stall_prev && reset_n) begin
            checkOutput("hold_valid", mem.mem_resp_valid, 1'b1);
            checkOutput("hold_data", mem.mem_rdata, stall_data);
        end
        if (mem.mem_resp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_resp", mem.mem_resp_valid, 1'b0);
            end else if (mem.mem_resp_ready) begin
                mon_e = sb.pop_front();
                pops.push_back(cyc);
                checkOutput("rdata", mem.mem_rdata, mon_e.data);
                mon_lat = cyc - mon_e.acc + 1;
`ifdef MEM_RESP_JITTER_EN
                if (mon_e.mode == 1)
                    checkOutput("latency_range", (mon_lat >= LAT) && (mon_lat <= LAT + 3), 1'b1);
                else
                    checkOutput("latency_min", mon_lat >= LAT, 1'b1);
`else
                if (mon_e.mode == 1)
                    checkOutput("latency", mon_lat, LAT);
                else
                    checkOutput("latency_min", mon_lat >= LAT, 1'b1);
`endif
            end
        end
        stall_prev = reset_n && mem.mem_resp_valid && !mem.mem_resp_ready;
        stall_data = mem.mem_rdata;
    end

    // Issue one request (called at posedge+1) and wait, bounded, for accept
    task automatic applyStimulus(input logic [47:0] a, input logic w, input line_t d, input int mode);
        int          n = 0;
        exp_t        e;
        logic [9:0]  ix;
        logic        o;
        mem.mem_addr      = a;
        mem.mem_write     = w;
        mem.mem_wdata     = d;
        mem.mem_req_valid = 1'b1;
        while (!mem.mem_req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checkOutput("req_ready_timeout", mem.mem_req_ready, 1'b1);
        end else begin
            ix     = a[15:6];
            o      = |a[47:16];
            e.data = (w || o) ? '0 : model[ix];
            e.acc  = cyc + 1;
            e.mode = mode;
            sb.push_back(e);
            if (w && !o) model[ix] = d;
            nreq++;
            if (o) noob++;
            @(posedge clk); #1;
        end
        mem.mem_req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain", sb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        line_t l0, l1, d5, d6, rnd, junk;
        logic  written [8];
        exp_t  e5;
        int    ix;
        logic  w, o;

        for (int k = 0; k < LINE_WORDS; k++) begin
            l1[k]   = DATA_WIDTH'(8'h11 * (k + 1));
            l0[k]   = DATA_WIDTH'(32'hA000_0000 + k);
            d5[k]   = DATA_WIDTH'(32'h5500_0000 + k);
            d6[k]   = DATA_WIDTH'(32'h6600_0000 + k);
            junk[k] = '1;
        end
        for (int k = 0; k < 8; k++) written[k] = 1'b0;

        mem.mem_addr       = '0;
        mem.mem_write      = 1'b0;
        mem.mem_wdata      = '0;
        mem.mem_req_valid  = 1'b0;
        mem.mem_resp_ready = 1'b1;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ready_in_reset", mem.mem_req_ready, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready_after_reset", mem.mem_req_ready, 1'b1);
        checkOutput("resp_valid_idle", mem.mem_resp_valid, 1'b0);
        checkOutput("rdata_idle", mem.mem_rdata, 512'd0);
        checkOutput("req_count_reset", req_count, 32'd0);
        checkOutput("oob_count_reset", oob_count, 32'd0);

        // Write then read the same line on consecutive edges
        applyStimulus(48'h40, 1'b1, l1, 1);
        applyStimulus(48'h40, 1'b0, '0, 1);
        waitDrain();
        checkOutput("req_count_wr_rd", req_count, 32'd2);

        // Out-of-range read and write, in-range lines unaffected
        applyStimulus(48'h0, 1'b1, l0, 1);
        applyStimulus(48'h1_0000_0000, 1'b0, '0, 1);
        applyStimulus(48'h1_0000_0040, 1'b1, junk, 1);
        applyStimulus(48'h0, 1'b0, '0, 1);
        applyStimulus(48'h40, 1'b0, '0, 1);
        waitDrain();
        checkOutput("oob_count", oob_count, 32'd2);
        checkOutput("req_count_oob", req_count, 32'd7);

        // Stalled responses fill the queue; fifth request waits for a pop
        mem.mem_resp_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) applyStimulus(48'h40, 1'b0, '0, 2);
        checkOutput("ready_full", mem.mem_req_ready, 1'b0);
        mem.mem_addr      = 48'h0;
        mem.mem_write     = 1'b0;
        mem.mem_req_valid = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        checkOutput("ready_full_stalled", mem.mem_req_ready, 1'b0);
        checkOutput("head_valid_stalled", mem.mem_resp_valid, 1'b1);
        pops.delete();
        mem.mem_resp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready_after_pop", mem.mem_req_ready, 1'b1);
        e5.data = model[0];
        e5.acc  = cyc + 1;
        e5.mode = 2;
        sb.push_back(e5);
        nreq++;
        @(posedge clk); #1;
        mem.mem_req_valid = 1'b0;
        waitDrain();
        checkOutput("stall_pop_count", pops.size(), 5);
        if (pops.size() >= 4) begin
            for (int k = 1; k < 4; k++) checkOutput("pop_consecutive", pops[k] - pops[k-1], 1);
        end
        checkOutput("req_count_stall", req_count, nreq);

        // Reset with three requests outstanding
        mem.mem_resp_ready = 1'b0;
        applyStimulus(48'h140, 1'b1, d5, 1);
        applyStimulus(48'h140, 1'b0, '0, 1);
        applyStimulus(48'h180, 1'b1, d6, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("ready_in_mid_reset", mem.mem_req_ready, 1'b0);
        @(posedge clk); #1;
        sb.delete();
        nreq = 0;
        noob = 0;
        reset_n = 1'b1;
        mem.mem_resp_ready = 1'b1;
        checkOutput("req_count_mid_reset", req_count, 32'd0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        checkOutput("no_resp_after_reset", mem.mem_resp_valid, 1'b0);
        applyStimulus(48'h140, 1'b0, '0, 1);
        applyStimulus(48'h180, 1'b0, '0, 1);
        waitDrain();

        // Random mix of reads, writes and out-of-range requests
        for (int n = 0; n < 60; n++) begin
            ix = $urandom_range(0, 7);
            w  = ($urandom_range(0, 1) == 1) || !written[ix];
            o  = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < LINE_WORDS; k++) rnd[k] = {$urandom, $urandom};
            if (w && !o) written[ix] = 1'b1;
            applyStimulus(o ? (48'h100_0000_0000 | 48'(ix * 64)) : 48'(ix * 64), w, rnd, 1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        waitDrain();
        checkOutput("req_count_final", req_count, nreq);
        checkOutput("oob_count_final", oob_count, noob);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
